vid2is_mode_controller: RTL and testbench
=========================================

Name: vid2is_mode_controller

Overview:
Sequencing controller between the Vid2IS resolution detector and the Vid2IS control-packet/stream path. It watches the detector's lock, stable, valid and toggle-style status signals. It qualifies a resolution over several fields, snapshots it, and hands it to the packetiser with a req/ack handshake. It then gates the video stream and drains cleanly at a field boundary when the resolution changes, lock is lost, or software clears go.

Parameters:
QUALIFY_FIELDS, 3, consecutive clean field starts needed before a resolution is accepted (1..15)
DRAIN_TIMEOUT, 4096, clock cycles to wait for field_done in DRAIN before forcing exit (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
go  in  1  software enable level
vid_locked  in  1  input video locked
start_new_field  in  1  single-cycle field-start strobe
det_update  in  1  detector update toggle
det_res_change  in  1  detector resolution-change toggle
det_stable  in  1  detector stable level
det_res_valid  in  1  detector resolution valid level
det_interlaced  in  1  detector interlaced flag
det_active_samples  in  15  {count[13:0], valid}
det_active_lines_f0  in  14  {count[12:0], valid}
det_active_lines_f1  in  14  {count[12:0], valid}
ctrl_ack  in  1  packetiser accepted the control packet
field_done  in  1  single-cycle strobe, stream path finished current field
width  out  14  snapshot active samples per line
height_f0  out  13  snapshot F0 active lines
height_f1  out  13  snapshot F1 active lines (0 if progressive)
interlaced  out  1  snapshot interlaced flag
ctrl_req  out  1  control-packet request
stream_en  out  1  enable video data into packetiser
status  out  3  FSM state encoding
res_change_count  out  8  saturating count of accepted resolution changes
irq  out  1  interrupt (see Optional Feature)

Behaviour:
- Reset: state IDLE; all outputs 0; toggle history registers = 0.
- Toggle detect: upd_evt = det_update ^ upd_q; chg_evt = det_res_change ^ chg_q. upd_q/chg_q update every cycle, including during reset release.
- good = vid_locked & det_stable & det_res_valid & bit0 of det_active_samples & bit0 of det_active_lines_f0 & (bit0 of det_active_lines_f1 | ~det_interlaced).
- States and encodings: IDLE=0, WAIT_LOCK=1, QUALIFY=2, SEND_CTRL=3, STREAM=4, DRAIN=5.
- IDLE -> WAIT_LOCK when go=1.
- WAIT_LOCK -> QUALIFY when good; clear qual_cnt.
- QUALIFY:
  - qual_cnt increments on start_new_field while good & ~upd_evt & ~chg_evt.
  - Any upd_evt, chg_evt or ~good clears qual_cnt in the same cycle; clear has priority over increment.
  - When qual_cnt reaches QUALIFY_FIELDS: capture width/height_f0/height_f1/interlaced from the inputs in that cycle (height_f1=0 if ~det_interlaced), then -> SEND_CTRL.
  - ~vid_locked -> WAIT_LOCK.
- SEND_CTRL:
  - ctrl_req=1 starting the cycle after entry; held until ctrl_ack sampled high.
  - On ack: ctrl_req=0 next cycle, -> STREAM.
  - ctrl_req never drops before ack, even on chg_evt or ~go. Those conditions are latched in pend_stop and acted on after the ack: -> DRAIN instead of STREAM.
- STREAM:
  - stream_en=1 asserted only at the first start_new_field after entry, never mid-field.
  - chg_evt, ~vid_locked or ~go -> DRAIN.
  - chg_evt also increments res_change_count (saturates at 255).
- DRAIN:
  - stream_en held until field_done, then deasserted the cycle after.
  - Timeout counter expires after DRAIN_TIMEOUT cycles: force stream_en=0 and set drain_timeout flag.
  - On exit: -> IDLE if go=0, else WAIT_LOCK.
  - If field_done and timeout expire in the same cycle, treat it as a normal exit (no timeout flag).
- go=0 in WAIT_LOCK or QUALIFY -> IDLE next cycle.
- Snapshot registers hold their values outside the capture cycle.
- Asynchronous reset mid-operation: all outputs 0 immediately. No handshake completion required; the packetiser is reset by the same rst_n.

Optional Feature:
VID2IS_MODE_IRQ_EN.
- Defined: sticky bits chg_irq (set on chg_evt in STREAM) and to_irq (set on DRAIN timeout).
- irq = chg_irq | to_irq, registered.
- Both sticky bits clear on a rising edge of go.
- Undefined: sticky logic absent, irq tied to 0.

Test Plan:
1. go=1, locked, good, 3 field strobes with w=1920, h0=540, h1=540, interlaced=1 -> snapshot 1920/540/540/1, ctrl_req rises; ack after 5 cycles -> STREAM; stream_en at next field strobe.
2. QUALIFY with det_update toggled after 2 fields -> qual_cnt resets; SEND_CTRL only after 3 further clean fields.
3. STREAM, det_res_change toggles -> DRAIN, res_change_count=1, irq=1 (macro on); field_done 10 cycles later -> stream_en=0, then WAIT_LOCK.
4. DRAIN with no field_done and DRAIN_TIMEOUT=16 -> stream_en=0 at cycle 16, to_irq set; field_done coincident with expiry -> no flag.
5. SEND_CTRL with go dropped before ack -> ctrl_req held until ack, then DRAIN, then IDLE; status reads 3,5,0.
6. rst_n asserted in STREAM -> all outputs 0 asynchronously; after release with go=1 -> WAIT_LOCK; 256 changes -> res_change_count stays 255.

Source files
------------

// File: rtl/vid2is_mode_controller_if.sv
// vid2is_mode_controller_if: detector status, packetiser handshake and snapshot bus around the mode controller
interface vid2is_mode_controller_if;
  logic        go;
  logic        vid_locked;
  logic        start_new_field;
  logic        det_update;
  logic        det_res_change;
  logic        det_stable;
  logic        det_res_valid;
  logic        det_interlaced;
  logic [14:0] det_active_samples;
  logic [13:0] det_active_lines_f0;
  logic [13:0] det_active_lines_f1;
  logic        ctrl_ack;
  logic        field_done;
  logic [13:0] width;
  logic [12:0] height_f0;
  logic [12:0] height_f1;
  logic        interlaced;
  logic        ctrl_req;
  logic        stream_en;
  logic [2:0]  status;
  logic [7:0]  res_change_count;
  logic        irq;
  modport master (
    output go, vid_locked, start_new_field, det_update, det_res_change, det_stable,
           det_res_valid, det_interlaced, det_active_samples, det_active_lines_f0,
           det_active_lines_f1, ctrl_ack, field_done,
    input  width, height_f0, height_f1, interlaced, ctrl_req, stream_en, status,
           res_change_count, irq
  );
  modport slave (
    input  go, vid_locked, start_new_field, det_update, det_res_change, det_stable,
           det_res_valid, det_interlaced, det_active_samples, det_active_lines_f0,
           det_active_lines_f1, ctrl_ack, field_done,
    output width, height_f0, height_f1, interlaced, ctrl_req, stream_en, status,
           res_change_count, irq
  );
endinterface

// File: rtl/vid2is_mode_controller.sv
// vid2is_mode_controller: qualifies a detected resolution, hands it to the packetiser and gates the stream at field boundaries; VID2IS_MODE_IRQ_EN adds sticky change/timeout interrupts
module vid2is_mode_controller #(
  parameter int QUALIFY_FIELDS = 3,
  parameter int DRAIN_TIMEOUT  = 4096
) (
  input logic clk,
  input logic rst_n,
  vid2is_mode_controller_if.slave bus
);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_LOCK = 3'd1;
  localparam logic [2:0] QUALIFY   = 3'd2;
  localparam logic [2:0] SEND_CTRL = 3'd3;
  localparam logic [2:0] STREAM    = 3'd4;
  localparam logic [2:0] DRAIN     = 3'd5;
  localparam int DW = $clog2(DRAIN_TIMEOUT);
  logic [2:0]    state, state_n;
  logic [3:0]    qual_cnt;
  logic [DW-1:0] drain_cnt;
  logic upd_q, chg_q, pend_stop;
  logic upd_evt, chg_evt, good, clean, qual_hit, ack, stop_req, stream_stop;
  logic drain_fd, drain_to, drain_exit;
  assign upd_evt     = bus.det_update ^ upd_q;
  assign chg_evt     = bus.det_res_change ^ chg_q;
  assign good        = bus.vid_locked & bus.det_stable & bus.det_res_valid & bus.det_active_samples[0]
                     & bus.det_active_lines_f0[0] & (bus.det_active_lines_f1[0] | ~bus.det_interlaced);
  assign clean       = good & ~upd_evt & ~chg_evt;
  assign qual_hit    = state == QUALIFY && bus.go && clean && bus.start_new_field
                     && qual_cnt == 4'(QUALIFY_FIELDS - 1);
  assign ack         = state == SEND_CTRL && bus.ctrl_req && bus.ctrl_ack;
  assign stop_req    = pend_stop | chg_evt | ~bus.go;
  assign stream_stop = state == STREAM && (chg_evt || !bus.vid_locked || !bus.go);
  assign drain_fd    = state == DRAIN && bus.field_done;
  assign drain_to    = state == DRAIN && !bus.field_done && drain_cnt == DW'(DRAIN_TIMEOUT - 1);
  assign drain_exit  = drain_fd | drain_to;
  assign bus.status  = state;
  // Next-state selection; go=0 wins in the pre-handshake states
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:      state_n = bus.go ? WAIT_LOCK : IDLE;
      WAIT_LOCK: state_n = !bus.go ? IDLE : good ? QUALIFY : WAIT_LOCK;
      QUALIFY:   state_n = !bus.go ? IDLE : !bus.vid_locked ? WAIT_LOCK : qual_hit ? SEND_CTRL : QUALIFY;
      SEND_CTRL: state_n = !ack ? SEND_CTRL : stop_req ? DRAIN : STREAM;
      STREAM:    state_n = stream_stop ? DRAIN : STREAM;
      DRAIN:     state_n = !drain_exit ? DRAIN : bus.go ? WAIT_LOCK : IDLE;
      default:   state_n = IDLE;
    endcase
  end
  // Toggle history follows the detector every cycle so a toggle is seen exactly once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_q <= 1'b0;
      chg_q <= 1'b0;
    end else begin
      upd_q <= bus.det_update;
      chg_q <= bus.det_res_change;
    end
  end
  // State, field qualification count, drain timer and stop request latched during the handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      qual_cnt  <= '0;
      drain_cnt <= '0;
      pend_stop <= 1'b0;
    end else begin
      state     <= state_n;
      qual_cnt  <= !(state == QUALIFY && clean) ? '0 : bus.start_new_field ? qual_cnt + 4'd1 : qual_cnt;
      drain_cnt <= state == DRAIN ? drain_cnt + 1'b1 : '0;
      pend_stop <= state == SEND_CTRL && !ack && stop_req;
    end
  end
  // Control request, field-aligned stream gate and saturating change counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ctrl_req         <= 1'b0;
      bus.stream_en        <= 1'b0;
      bus.res_change_count <= '0;
    end else begin
      bus.ctrl_req         <= state == SEND_CTRL && !ack;
      bus.stream_en        <= (state == STREAM && !stream_stop && bus.start_new_field) ? 1'b1
                            : drain_exit ? 1'b0 : bus.stream_en;
      bus.res_change_count <= (state == STREAM && chg_evt && bus.res_change_count != 8'hFF)
                            ? bus.res_change_count + 8'd1 : bus.res_change_count;
    end
  end
  // Resolution snapshot taken in the accepting cycle only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.width      <= '0;
      bus.height_f0  <= '0;
      bus.height_f1  <= '0;
      bus.interlaced <= 1'b0;
    end else if (qual_hit) begin
      bus.width      <= bus.det_active_samples[14:1];
      bus.height_f0  <= bus.det_active_lines_f0[13:1];
      bus.height_f1  <= bus.det_interlaced ? bus.det_active_lines_f1[13:1] : '0;
      bus.interlaced <= bus.det_interlaced;
    end
  end
`ifdef VID2IS_MODE_IRQ_EN
  logic go_q, chg_irq, to_irq, chg_irq_n, to_irq_n;
  assign chg_irq_n = (bus.go & ~go_q) ? 1'b0 : chg_irq | (state == STREAM && chg_evt);
  assign to_irq_n  = (bus.go & ~go_q) ? 1'b0 : to_irq | drain_to;
  // Sticky interrupt sources, cleared by a rising edge of go
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      go_q    <= 1'b0;
      chg_irq <= 1'b0;
      to_irq  <= 1'b0;
      bus.irq <= 1'b0;
    end else begin
      go_q    <= bus.go;
      chg_irq <= chg_irq_n;
      to_irq  <= to_irq_n;
      bus.irq <= chg_irq_n | to_irq_n;
    end
  end
`else
  assign bus.irq = 1'b0;
`endif
endmodule

// File: tb/tb_vid2is_mode_controller.sv
// tb_vid2is_mode_controller: directed sequence with randomized resolutions and timings against a spec-level expectation model
module tb_vid2is_mode_controller;
  localparam int QF = 3;
  localparam int DT = 16;
`ifdef VID2IS_MODE_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  int exp_cnt = 0;
  logic exp_irq = 1'b0;
  vid2is_mode_controller_if bus();
  vid2is_mode_controller #(.QUALIFY_FIELDS(QF), .DRAIN_TIMEOUT(DT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (%0d/%0d checks passed)", n_pass, n_chk);
    $fatal(1, "watchdog");
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask
  task automatic set_res(input logic [13:0] w, input logic [12:0] h0, input logic [12:0] h1, input logic il);
    bus.vid_locked          = 1'b1;
    bus.det_stable          = 1'b1;
    bus.det_res_valid       = 1'b1;
    bus.det_interlaced      = il;
    bus.det_active_samples  = {w, 1'b1};
    bus.det_active_lines_f0 = {h0, 1'b1};
    bus.det_active_lines_f1 = {h1, 1'b1};
  endtask
  task automatic pulse();
    bus.start_new_field = 1'b1;
    tick();
    bus.start_new_field = 1'b0;
  endtask
  // From WAIT_LOCK: random resolution, QF clean fields with random gaps, ends with ctrl_req high
  task automatic qualify();
    logic [13:0] w;
    logic [12:0] h0, h1;
    logic il;
    w  = 14'($urandom_range(1, 16383));
    h0 = 13'($urandom_range(1, 8191));
    h1 = 13'($urandom_range(1, 8191));
    il = 1'($urandom_range(0, 1));
    set_res(w, h0, h1, il);
    if (!il) bus.det_active_lines_f1[0] = 1'($urandom_range(0, 1));
    tick();
    chk("qual_enter", bus.status, 2);
    for (int i = 0; i < QF; i++) begin
      if (i > 0) repeat ($urandom_range(0, 3)) tick();
      pulse();
      if (i < QF - 1) chk("qual_wait", bus.status, 2);
    end
    chk("snap_status", bus.status, 3);
    chk("snap_width", bus.width, w);
    chk("snap_h0", bus.height_f0, h0);
    chk("snap_h1", bus.height_f1, il ? h1 : 13'd0);
    chk("snap_il", bus.interlaced, il);
    chk("req_entry", bus.ctrl_req, 0);
    tick();
    chk("req_rise", bus.ctrl_req, 1);
  endtask
  task automatic ack_after(input int lat, input int exp_st);
    repeat (lat - 1) tick();
    chk("req_hold", bus.ctrl_req, 1);
    bus.ctrl_ack = 1'b1;
    tick();
    bus.ctrl_ack = 1'b0;
    chk("ack_status", bus.status, exp_st);
    chk("req_drop", bus.ctrl_req, 0);
  endtask
  task automatic stream_on();
    repeat ($urandom_range(1, 3)) tick();
    chk("no_mid_field", bus.stream_en, 0);
    pulse();
    chk("stream_on", bus.stream_en, 1);
  endtask
  task automatic go_rise();
    bus.go = 1'b0;
    tick();
    bus.go = 1'b1;
    tick();
    exp_irq = 1'b0;
    chk("go_rise_status", bus.status, 1);
    chk("go_rise_irq", bus.irq, exp_irq);
  endtask
  initial begin
    bus.go = 1'b0; bus.vid_locked = 1'b0; bus.start_new_field = 1'b0;
    bus.det_update = 1'b0; bus.det_res_change = 1'b0; bus.det_stable = 1'b0;
    bus.det_res_valid = 1'b0; bus.det_interlaced = 1'b0; bus.det_active_samples = '0;
    bus.det_active_lines_f0 = '0; bus.det_active_lines_f1 = '0;
    bus.ctrl_ack = 1'b0; bus.field_done = 1'b0;
    #12;
    chk("rst_status", bus.status, 0);
    chk("rst_req", bus.ctrl_req, 0);
    chk("rst_stream", bus.stream_en, 0);
    chk("rst_width", bus.width, 0);
    chk("rst_count", bus.res_change_count, 0);
    chk("rst_irq", bus.irq, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_hold", bus.status, 0);
    bus.go = 1'b1;
    bus.vid_locked = 1'b1;
    tick();
    chk("wait_lock", bus.status, 1);
    tick();
    chk("wait_not_good", bus.status, 1);
    // Qualify, handshake and field-aligned streaming with random resolutions; exit via go=0
    for (int k = 0; k < 3; k++) begin
      qualify();
      ack_after(k == 0 ? 5 : $urandom_range(1, 6), 4);
      stream_on();
      bus.go = 1'b0;
      tick();
      chk("go_drain", bus.status, 5);
      chk("go_drain_en", bus.stream_en, 1);
      bus.field_done = 1'b1;
      tick();
      bus.field_done = 1'b0;
      chk("go_exit_en", bus.stream_en, 0);
      chk("go_exit_idle", bus.status, 0);
      bus.go = 1'b1;
      tick();
      chk("restart", bus.status, 1);
    end
    // Detector update toggle restarts qualification, even together with a field strobe
    set_res(14'd1280, 13'd720, 13'd0, 1'b0);
    bus.det_active_lines_f1 = '0;
    tick();
    chk("t2_enter", bus.status, 2);
    pulse(); chk("t2_f1", bus.status, 2);
    pulse(); chk("t2_f2", bus.status, 2);
    bus.det_update = ~bus.det_update;
    pulse(); chk("t2_toggle", bus.status, 2);
    pulse(); chk("t2_c1", bus.status, 2);
    pulse(); chk("t2_c2", bus.status, 2);
    pulse(); chk("t2_c3", bus.status, 3);
    chk("t2_width", bus.width, 1280);
    chk("t2_h1", bus.height_f1, 0);
    tick();
    ack_after(1, 4);
    // Resolution change while streaming: drain until field_done
    stream_on();
    bus.det_res_change = ~bus.det_res_change;
    tick();
    exp_cnt = exp_cnt < 255 ? exp_cnt + 1 : 255;
    exp_irq = IRQ_ON;
    chk("t3_drain", bus.status, 5);
    chk("t3_count", bus.res_change_count, exp_cnt);
    chk("t3_irq", bus.irq, exp_irq);
    repeat (9) tick();
    chk("t3_hold_en", bus.stream_en, 1);
    bus.field_done = 1'b1;
    tick();
    bus.field_done = 1'b0;
    chk("t3_off", bus.stream_en, 0);
    chk("t3_wait", bus.status, 1);
    chk("t3_irq_sticky", bus.irq, exp_irq);
    go_rise();
    // field_done coincident with timeout expiry: normal exit, no timeout flag
    qualify();
    ack_after(2, 4);
    stream_on();
    bus.vid_locked = 1'b0;
    tick();
    chk("t4a_drain", bus.status, 5);
    repeat (DT - 1) tick();
    chk("t4a_pre_status", bus.status, 5);
    chk("t4a_pre_en", bus.stream_en, 1);
    bus.field_done = 1'b1;
    tick();
    bus.field_done = 1'b0;
    chk("t4a_exit", bus.status, 1);
    chk("t4a_en", bus.stream_en, 0);
    chk("t4a_irq", bus.irq, exp_irq);
    // No field_done: forced exit after DT cycles in DRAIN
    qualify();
    ack_after(3, 4);
    stream_on();
    bus.vid_locked = 1'b0;
    tick();
    chk("t4b_drain", bus.status, 5);
    repeat (DT - 1) tick();
    chk("t4b_pre_status", bus.status, 5);
    chk("t4b_pre_en", bus.stream_en, 1);
    tick();
    exp_irq = IRQ_ON;
    chk("t4b_exit", bus.status, 1);
    chk("t4b_en", bus.stream_en, 0);
    chk("t4b_irq", bus.irq, exp_irq);
    // go dropped before ack: request held, then drain to IDLE
    qualify();
    bus.go = 1'b0;
    repeat (3) tick();
    chk("t5_req_held", bus.ctrl_req, 1);
    chk("t5_status", bus.status, 3);
    ack_after(1, 5);
    chk("t5_no_stream", bus.stream_en, 0);
    bus.field_done = 1'b1;
    tick();
    bus.field_done = 1'b0;
    chk("t5_idle", bus.status, 0);
    bus.go = 1'b1;
    tick();
    exp_irq = 1'b0;
    chk("t5_restart", bus.status, 1);
    chk("t5_irq_clr", bus.irq, exp_irq);
    // Resolution change during the handshake: drain afterwards, not counted
    qualify();
    bus.det_res_change = ~bus.det_res_change;
    tick();
    chk("t5b_req_held", bus.ctrl_req, 1);
    ack_after(2, 5);
    chk("t5b_count", bus.res_change_count, exp_cnt);
    chk("t5b_irq", bus.irq, exp_irq);
    bus.field_done = 1'b1;
    tick();
    bus.field_done = 1'b0;
    chk("t5b_wait", bus.status, 1);
    // Asynchronous reset while streaming
    qualify();
    ack_after(1, 4);
    stream_on();
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_status", bus.status, 0);
    chk("t6_en", bus.stream_en, 0);
    chk("t6_width", bus.width, 0);
    chk("t6_h0", bus.height_f0, 0);
    chk("t6_count", bus.res_change_count, 0);
    tick();
    tick();
    rst_n = 1'b1;
    exp_cnt = 0;
    tick();
    chk("t6_wait", bus.status, 1);
    // 256 accepted changes: counter saturates
    for (int k = 1; k <= 256; k++) begin
      tick();
      bus.start_new_field = 1'b1;
      repeat (QF) tick();
      bus.start_new_field = 1'b0;
      tick();
      bus.ctrl_ack = 1'b1;
      tick();
      bus.ctrl_ack = 1'b0;
      bus.det_res_change = ~bus.det_res_change;
      tick();
      exp_cnt = exp_cnt < 255 ? exp_cnt + 1 : 255;
      chk("sat_drain", bus.status, 5);
      if (k == 1 || k == 255 || k == 256) chk("sat_count", bus.res_change_count, exp_cnt);
      bus.field_done = 1'b1;
      tick();
      bus.field_done = 1'b0;
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
